// File: rtl/time_edit_controller_pkg.sv
// Shared constants for the time-edit controller and the edit datapath.
// The FSM state encodings deliberately match the select codes, so each
// edit state maps directly onto the field it edits.
package time_edit_controller_pkg;

    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_SEC  = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_HOUR = 2'd3;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_EDIT_SEC  = 2'd1;
    localparam logic [1:0] ST_EDIT_MIN  = 2'd2;
    localparam logic [1:0] ST_EDIT_HOUR = 2'd3;

    // Mode button order: RUN -> HOUR -> MIN -> SEC -> RUN
    function automatic logic [1:0] next_edit_state(input logic [1:0] state);
        case (state)
            ST_RUN:       next_edit_state = ST_EDIT_HOUR;
            ST_EDIT_HOUR: next_edit_state = ST_EDIT_MIN;
            ST_EDIT_MIN:  next_edit_state = ST_EDIT_SEC;
            default:      next_edit_state = ST_RUN;
        endcase
    endfunction

    // Field presented to the datapath for a given controller state
    function automatic logic [1:0] state_select(input logic [1:0] state);
        case (state)
            ST_EDIT_HOUR: state_select = SELECT_HOUR;
            ST_EDIT_MIN:  state_select = SELECT_MIN;
            ST_EDIT_SEC:  state_select = SELECT_SEC;
            default:      state_select = SELECT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_edit_controller_if.sv
// Button inputs and edit-control outputs of the time-edit controller.
// slave: the controller itself; master: the side that drives the buttons
// and consumes select/increment/run_en/commit/blink.
interface time_edit_controller_if;

    logic       mode_btn;
    logic       inc_btn;
    logic       tick_1hz;
    logic [1:0] select;
    logic       increment;
    logic       run_en;
    logic       commit;
    logic       blink;

    modport master (
        output mode_btn, inc_btn, tick_1hz,
        input  select, increment, run_en, commit, blink
    );

    modport slave (
        input  mode_btn, inc_btn, tick_1hz,
        output select, increment, run_en, commit, blink
    );

endinterface

// File: rtl/time_edit_controller_edge_detect.sv
// Registered rising-edge detector for a debounced button level.
// After reset the detector stays disarmed until the button has been seen
// low, so a button held through reset release never produces an edge.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic rise
);

    logic btn_q;
    logic armed;

    // Button history and the release-required arming flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn;
            if (!btn) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise = btn & ~btn_q & armed;

endmodule

// File: rtl/time_edit_controller.sv
// Time-edit flow controller for the digital clock: mode/increment buttons
// to select code, increment pulses, run/pause, commit and blink.
// Optional macro TIME_EDIT_AUTO_REPEAT_EN builds the hold-to-repeat logic
// for the increment button; without it only button edges increment.
module time_edit_controller
    import time_edit_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    time_edit_controller_if.slave bus
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [1:0]      select_q;
    logic            run_en_q;
    logic            increment_q;
    logic            commit_q;
    logic            blink_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_inc;

    logic mode_rise;
    logic inc_rise;
    logic edit_active;
    logic timeout_hit;
    logic repeat_fire;
    logic state_change;
    logic increment_d;
    logic commit_d;

    edge_detect u_mode_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bus.mode_btn),
        .rise    (mode_rise)
    );

    edge_detect u_inc_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bus.inc_btn),
        .rise    (inc_rise)
    );

    assign edit_active = (state_q != ST_RUN);

    // Increment activity in the same cycle restarts the inactivity window,
    // so it also suppresses a timeout that would otherwise fire now.
    assign to_cnt_inc  = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + TO_W'(1);
    assign timeout_hit = edit_active & bus.tick_1hz & ~inc_rise & ~repeat_fire
                         & (to_cnt_inc >= TO_LIMIT);

`ifdef TIME_EDIT_AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0]  REP_RELOAD = REP_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [REP_W-1:0]  rep_cnt_q;
    logic              holding;

    assign holding     = edit_active & bus.inc_btn;
    assign repeat_fire = holding & (hold_cnt_q == HOLD_LIMIT) & (rep_cnt_q == '0)
                         & ~mode_rise;

    // Hold counter saturates at the hold threshold; the repeat counter then
    // reloads on every repeat pulse and counts down to the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else if (!holding || state_change) begin
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            if (hold_cnt_q != HOLD_LIMIT) begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
            if (repeat_fire) begin
                rep_cnt_q <= REP_RELOAD;
            end else if (rep_cnt_q != '0) begin
                rep_cnt_q <= rep_cnt_q - REP_W'(1);
            end
        end
    end
`else
    logic unused_repeat_cfg;

    assign repeat_fire       = 1'b0;
    assign unused_repeat_cfg = ^{32'(HOLD_CYCLES), 32'(REPEAT_CYCLES)};
`endif

    // Next state and pulse decisions: timeout beats mode, mode beats increment
    always_comb begin
        state_d     = state_q;
        commit_d    = 1'b0;
        increment_d = 1'b0;
        if (timeout_hit) begin
            state_d  = ST_RUN;
            commit_d = 1'b1;
        end else if (mode_rise) begin
            state_d  = next_edit_state(state_q);
            commit_d = (state_q == ST_EDIT_SEC);
        end else if (edit_active && (inc_rise || repeat_fire)) begin
            increment_d = 1'b1;
        end
    end

    assign state_change = (state_d != state_q);

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            select_q    <= SELECT_NONE;
            run_en_q    <= 1'b1;
            increment_q <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            select_q    <= state_select(state_d);
            run_en_q    <= (state_d == ST_RUN);
            increment_q <= increment_d;
            commit_q    <= commit_d;
        end
    end

    // Inactivity timer: counts ticks while editing, cleared by any activity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else if (!edit_active || state_change || mode_rise || inc_rise || repeat_fire) begin
            to_cnt_q <= '0;
        end else if (bus.tick_1hz) begin
            to_cnt_q <= to_cnt_inc;
        end
    end

    // Blink phase: off in RUN, blanked on entry to a field, toggles each tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= 1'b0;
        end else if (state_d == ST_RUN) begin
            blink_q <= 1'b0;
        end else if (state_change) begin
            blink_q <= 1'b1;
        end else if (bus.tick_1hz) begin
            blink_q <= ~blink_q;
        end
    end

    assign bus.select    = select_q;
    assign bus.run_en    = run_en_q;
    assign bus.increment = increment_q;
    assign bus.commit    = commit_q;
    assign bus.blink     = blink_q;

endmodule

// File: tb/tb_time_edit_controller.sv
// Scoreboard bench for time_edit_controller with TIMEOUT_TICKS=3,
// HOLD_CYCLES=8, REPEAT_CYCLES=4. Honours TIME_EDIT_AUTO_REPEAT_EN.
module tb_time_edit_controller;

`ifdef TIME_EDIT_AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] sel;
        logic       incr;
        logic       run;
        logic       commit;
        logic       blink;
    } outs_t;

    typedef struct {
        int    due;
        outs_t exp;
        string tag;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   assert_count = 0;
    int   fail_count = 0;

    sb_entry_t sb_queue[$];

    time_edit_controller_if bus ();

    time_edit_controller #(
        .TIMEOUT_TICKS (3),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic outs_t ex(input logic [1:0] s, input logic i, input logic r,
                                 input logic c, input logic b);
        return {s, i, r, c, b};
    endfunction

    task automatic checkOutput(input string tag, input outs_t exp);
        outs_t act;
        act = {bus.select, bus.increment, bus.run_en, bus.commit, bus.blink};
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s @cyc %0d: got sel=%0d inc=%0b run=%0b commit=%0b blink=%0b, expected sel=%0d inc=%0b run=%0b commit=%0b blink=%0b",
                     tag, cyc, act.sel, act.incr, act.run, act.commit, act.blink,
                     exp.sel, exp.incr, exp.run, exp.commit, exp.blink);
        end
    endtask

    // One cycle of button/tick stimulus; expectation due after the next edge
    task automatic applyStimulus(input string tag, input logic m, input logic i,
                                 input logic t, input outs_t exp);
        sb_entry_t e;
        @(posedge clk);
        #1;
        bus.mode_btn = m;
        bus.inc_btn  = i;
        bus.tick_1hz = t;
        e.due = cyc + 1;
        e.exp = exp;
        e.tag = tag;
        sb_queue.push_back(e);
    endtask

    // Monitor: compares every expectation whose cycle has arrived
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb_queue.size() > 0 && sb_queue[0].due <= cyc) begin
                e = sb_queue.pop_front();
                checkOutput(e.tag, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        outs_t r_idle, r_commit, e_hour, e_min, e_sec, e_tmp;
        r_idle   = ex(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        r_commit = ex(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        e_hour   = ex(2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        e_min    = ex(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        e_sec    = ex(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        reset_n      = 1'b0;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        bus.tick_1hz = 1'b0;

        applyStimulus("reset_state", 0, 0, 0, r_idle);
        applyStimulus("reset_state", 0, 0, 0, r_idle);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        applyStimulus("idle", 0, 0, 0, r_idle);

        // Mode cycling: HOUR, MIN, SEC, then back to RUN with one commit
        applyStimulus("mode_hour", 1, 0, 0, e_hour);
        applyStimulus("mode_hour_rel", 0, 0, 0, e_hour);
        applyStimulus("mode_min", 1, 0, 0, e_min);
        applyStimulus("mode_min_rel", 0, 0, 0, e_min);
        applyStimulus("mode_sec", 1, 0, 0, e_sec);
        applyStimulus("mode_sec_rel", 0, 0, 0, e_sec);
        applyStimulus("mode_run_commit", 1, 0, 0, r_commit);
        applyStimulus("commit_one_cycle", 0, 0, 0, r_idle);

        // Five increment presses in EDIT_MIN
        applyStimulus("to_hour", 1, 0, 0, e_hour);
        applyStimulus("to_hour_rel", 0, 0, 0, e_hour);
        applyStimulus("to_min", 1, 0, 0, e_min);
        applyStimulus("to_min_rel", 0, 0, 0, e_min);
        e_tmp = ex(2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus("min_inc_pulse", 0, 1, 0, e_tmp);
            applyStimulus("min_inc_end", 0, 0, 0, e_min);
        end
        applyStimulus("to_sec", 1, 0, 0, e_sec);
        applyStimulus("to_sec_rel", 0, 0, 0, e_sec);
        applyStimulus("to_run", 1, 0, 0, r_commit);
        applyStimulus("to_run_rel", 0, 0, 0, r_idle);

        // Increment presses in RUN are ignored
        for (int k = 0; k < 3; k++) begin
            applyStimulus("run_inc_ignored", 0, 1, 0, r_idle);
            applyStimulus("run_inc_rel", 0, 0, 0, r_idle);
        end

        // Timeout from EDIT_HOUR after three ticks; blink 1,0,1 then 0
        applyStimulus("to_hour_to", 1, 0, 0, e_hour);
        applyStimulus("to_hour_to_rel", 0, 0, 0, e_hour);
        applyStimulus("tick1_blink0", 0, 0, 1, ex(2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus("tick1_hold", 0, 0, 0, ex(2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus("tick2_blink1", 0, 0, 1, e_hour);
        applyStimulus("tick2_hold", 0, 0, 0, e_hour);
        applyStimulus("tick3_timeout", 0, 0, 1, r_commit);
        applyStimulus("timeout_after", 0, 0, 0, r_idle);

        // Simultaneous mode and inc edges: mode wins, increment dropped
        applyStimulus("sim_hour", 1, 0, 0, e_hour);
        applyStimulus("sim_hour_rel", 0, 0, 0, e_hour);
        applyStimulus("sim_mode_inc", 1, 1, 0, e_min);
        applyStimulus("sim_rel", 0, 0, 0, e_min);

        // Timeout and mode edge together in EDIT_SEC: one commit
        applyStimulus("tm_sec", 1, 0, 0, e_sec);
        applyStimulus("tm_sec_rel", 0, 0, 0, e_sec);
        applyStimulus("tm_tick1", 0, 0, 1, ex(2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus("tm_tick1_rel", 0, 0, 0, ex(2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus("tm_tick2", 0, 0, 1, e_sec);
        applyStimulus("tm_tick2_rel", 0, 0, 0, e_sec);
        applyStimulus("tm_tick3_mode", 1, 0, 1, r_commit);
        applyStimulus("tm_single_commit", 0, 0, 0, r_idle);

        // Hold increment for 20 cycles in EDIT_SEC
        applyStimulus("ar_hour", 1, 0, 0, e_hour);
        applyStimulus("ar_hour_rel", 0, 0, 0, e_hour);
        applyStimulus("ar_min", 1, 0, 0, e_min);
        applyStimulus("ar_min_rel", 0, 0, 0, e_min);
        applyStimulus("ar_sec", 1, 0, 0, e_sec);
        applyStimulus("ar_sec_rel", 0, 0, 0, e_sec);
        for (int k = 1; k <= 20; k++) begin
            e_tmp = e_sec;
            e_tmp.incr = (k == 1) || (AUTO_REPEAT && (k == 9 || k == 13 || k == 17));
            applyStimulus("hold_inc", 0, 1, 0, e_tmp);
        end
        applyStimulus("hold_release", 0, 0, 0, e_sec);
        applyStimulus("ar_run", 1, 0, 0, r_commit);
        applyStimulus("ar_run_rel", 0, 0, 0, r_idle);

        // Reset mid-edit in EDIT_MIN, increment held through reset release
        applyStimulus("rst_hour", 1, 0, 0, e_hour);
        applyStimulus("rst_hour_rel", 0, 0, 0, e_hour);
        applyStimulus("rst_min", 1, 0, 0, e_min);
        applyStimulus("rst_min_rel", 0, 0, 0, e_min);
        @(posedge clk);
        #3;
        reset_n     = 1'b0;
        bus.inc_btn = 1'b1;
        #1;
        checkOutput("reset_immediate", r_idle);
        applyStimulus("in_reset", 0, 1, 0, r_idle);
        applyStimulus("in_reset", 0, 1, 0, r_idle);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        applyStimulus("held_after_reset", 0, 1, 0, r_idle);
        applyStimulus("held_mode_hour", 1, 1, 0, e_hour);
        applyStimulus("held_no_inc", 0, 1, 0, e_hour);
        applyStimulus("inc_released", 0, 0, 0, e_hour);
        applyStimulus("inc_repress", 0, 1, 0, ex(2'd3, 1'b1, 1'b0, 1'b0, 1'b1));
        applyStimulus("inc_repress_rel", 0, 0, 0, e_hour);
        applyStimulus("end_min", 1, 0, 0, e_min);
        applyStimulus("end_min_rel", 0, 0, 0, e_min);
        applyStimulus("end_sec", 1, 0, 0, e_sec);
        applyStimulus("end_sec_rel", 0, 0, 0, e_sec);
        applyStimulus("end_run", 1, 0, 0, r_commit);
        applyStimulus("end_run_rel", 0, 0, 0, r_idle);

        // Let the monitor drain the scoreboard, bounded
        for (int w = 0; w < 10 && sb_queue.size() > 0; w++) begin
            @(posedge clk);
            #3;
        end
        if (sb_queue.size() > 0) begin
            fail_count++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_queue.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/time_edit_controller.md
# time_edit_controller

Sequences the user-facing time-edit flow for the digital clock. It turns debounced mode/increment buttons into the `select` code, one-cycle `increment` pulses and the run/pause control consumed by the time-edit datapath and seconds counter. It sits between the button debouncers and that datapath, and drives the display blink enable.

## Interface
- `TIMEOUT_TICKS`, default 10: number of `tick_1hz` pulses without button activity before edit mode is left automatically.
- `HOLD_CYCLES`, default 50_000_000: clock cycles the increment button must stay held before auto-repeat starts.
- `REPEAT_CYCLES`, default 10_000_000: clock cycles between auto-repeat increments.
- `clk`  in  1  system clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode_btn`  in  1  debounced, synchronized level of the mode button.
- `inc_btn`  in  1  debounced, synchronized level of the increment button.
- `tick_1hz`  in  1  one-cycle pulse, once per second.
- `select`  out  2  field under edit: `SELECT_NONE`=0, `SELECT_SEC`=1, `SELECT_MIN`=2, `SELECT_HOUR`=3.
- `increment`  out  1  one-cycle pulse; the datapath bumps the selected field.
- `run_en`  out  1  1 = seconds counter advances; 0 = clock paused for editing.
- `commit`  out  1  one-cycle pulse on leaving edit mode.
- `blink`  out  1  display blank phase for the selected field.

## Operation
- FSM states: `RUN`, `EDIT_HOUR`, `EDIT_MIN`, `EDIT_SEC`.
- Transitions on a `mode_btn` rising edge: RUN→EDIT_HOUR→EDIT_MIN→EDIT_SEC→RUN.
- Edges are detected against a registered copy of each button.
- `select` per state: RUN=NONE, EDIT_HOUR=HOUR, EDIT_MIN=MIN, EDIT_SEC=SEC.
- `run_en` is 1 only in RUN.
- `commit` pulses on the EDIT_SEC→RUN transition and on timeout exit.
- `inc_btn` rising edge in an edit state gives one `increment` pulse. It is ignored in RUN.
- Simultaneous mode and inc edges in the same cycle: mode wins; the increment is dropped.
- Timeout counter:
  - Counts `tick_1hz` pulses while in an edit state.
  - Cleared by any button rising edge, any state change, and entry to RUN.
  - On reaching `TIMEOUT_TICKS` the FSM goes to RUN with a `commit` pulse.
  - If a timeout and a mode edge occur in the same cycle, the FSM goes to RUN with exactly one `commit`.
- `blink`:
  - Toggles on each `tick_1hz` in an edit state.
  - Forced to 0 in RUN.
  - Reset to 1 on entry to each edit state, so the field blanks immediately.
- Counters are width-sized with `$clog2(param+1)` and saturate; no wrap.

## Timing
- Reset values: state RUN, `select`=0, `increment`=0, `run_en`=1, `commit`=0, `blink`=0, all counters 0, button history registers 0.
- All outputs are registered.
- Button sampled high in cycle N (low in N−1) → state/`select`/`run_en` change and `increment`/`commit` pulse in cycle N+1.
- `increment` and `commit` are exactly one cycle wide and never asserted in consecutive cycles from a single edge.
- `tick_1hz` in cycle N → `blink` toggles, or timeout takes effect, in cycle N+1.
- `reset_n` low mid-edit aborts immediately to reset values. No `commit` is emitted.
- A button held through reset release produces no edge until it is released and pressed again, because history resets to 0 and release is required.

## Configuration
- Macro `TIME_EDIT_AUTO_REPEAT_EN`.
- Defined:
  - While `inc_btn` stays high in an edit state, a hold counter runs.
  - After `HOLD_CYCLES` cycles, `increment` pulses, then again every `REPEAT_CYCLES` cycles until release or state change.
  - Repeat pulses also clear the timeout counter.
- Undefined: the hold/repeat counters are not built; only edges increment. The `HOLD_CYCLES`/`REPEAT_CYCLES` parameters remain but are unused.

## Structure
- `SELECT_*` codes and the FSM state encodings go in the shared constants include, alongside the existing select codes. Edit datapath and controller must agree.
- One sub-module: `edge_detect` (registered rising-edge detector, active-low async reset), instantiated once per button.
- Counters and the FSM stay inline.

## Test plan
Bench uses `TIMEOUT_TICKS`=3, `HOLD_CYCLES`=8, `REPEAT_CYCLES`=4.
- Reset, then 3 mode presses → `select` 3,2,1, each one cycle after its edge, `run_en`=0; 4th press → `select`=0, `run_en`=1, one `commit` pulse.
- In EDIT_MIN, 5 separate inc presses → exactly 5 one-cycle `increment` pulses, `select`=2 throughout; inc presses in RUN → no pulses.
- In EDIT_HOUR, no buttons, 3 `tick_1hz` pulses → RUN with `commit` one cycle after the 3rd tick; `blink` reads 1,0,1,0 across entry and ticks.
- Mode and inc rising in the same cycle in EDIT_HOUR → EDIT_MIN, no `increment`.
- With `TIME_EDIT_AUTO_REPEAT_EN`, hold inc 20 cycles in EDIT_SEC → pulses at cycle 1 (edge), 9, 13, 17; without the macro → only cycle 1.
- Drop `reset_n` mid-edit in EDIT_MIN → immediate reset values, no `commit`; held `inc_btn` after release → no `increment`.
